// File: rtl/vx_ibuffer_reader_pkg.sv
// Shared types and encodings for the instruction-buffer reader slice.
package vx_ibuffer_reader_pkg;

  localparam int UUID_W      = 16;
  localparam int NW_W        = 2;
  localparam int NUM_THREADS = 4;
  localparam int EX_W        = 2;
  localparam int OP_W        = 4;
  localparam int MOD_W       = 3;
  localparam int XLEN        = 32;
  localparam int REG_W       = 6;

  localparam logic [EX_W-1:0]  EX_ALU        = 2'd0;
  localparam logic [EX_W-1:0]  EX_LSU        = 2'd1;
  localparam logic [OP_W-1:0]  INST_ALU_ADD  = 4'h0;
  localparam logic [OP_W-1:0]  INST_ALU_MMUL = 4'hE;
  localparam logic [MOD_W-1:0] MMUL_MOD_PART = 3'b010;
  localparam logic [MOD_W-1:0] MMUL_MOD_LAST = 3'b000;

  // MMUL grouping FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GRP1 = 2'd1;
  localparam logic [1:0] ST_GRP2 = 2'd2;

  typedef struct packed {
    logic [UUID_W-1:0]      uuid;
    logic [NW_W-1:0]        wis;
    logic [NUM_THREADS-1:0] tmask;
    logic [EX_W-1:0]        ex_type;
    logic [OP_W-1:0]        op_type;
    logic [MOD_W-1:0]       op_mod;
    logic                   wb;
    logic                   use_PC;
    logic                   use_imm;
    logic [XLEN-1:0]        PC;
    logic [XLEN-1:0]        imm;
    logic [REG_W-1:0]       rd;
    logic [REG_W-1:0]       rs1;
    logic [REG_W-1:0]       rs2;
    logic [REG_W-1:0]       rs3;
    logic                   is_mstore;
  } ibuf_entry_t;

  localparam int IBUF_DATAW = $bits(ibuf_entry_t);

  // Entry plus the group tags computed when it was accepted
  typedef struct packed {
    ibuf_entry_t data;
    logic        first;
    logic        last;
  } ibuf_tagged_t;

  localparam int TAGGED_W = $bits(ibuf_tagged_t);

  function automatic logic is_mmul(input ibuf_entry_t e);
    return (e.ex_type == EX_ALU) && (e.op_type == INST_ALU_MMUL);
  endfunction

endpackage

// File: rtl/vx_ibuffer_reader_ebuf.sv
// Two-entry elastic buffer: registered output stage plus one skid entry.
// Upstream ready depends only on skid occupancy, never on ready_out.
module vx_ibuffer_reader_ebuf #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
);

  logic             skid_valid;
  logic [DATAW-1:0] skid_data;
  logic             push;
  logic             load;

  assign ready_in = !skid_valid;
  assign push     = valid_in && ready_in;
  assign load     = !valid_out || ready_out;

  // Occupancy: output reloads from skid first, else directly from input
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load) begin
      valid_out  <= skid_valid || push;
      skid_valid <= 1'b0;
    end else if (push) begin
      skid_valid <= 1'b1;
    end
  end

  // Payload registers carry no reset; they are qualified by the valid flags
  always_ff @(posedge clk) begin
    if (load) begin
      data_out <= skid_valid ? skid_data : data_in;
    end
    if (!load && push) begin
      skid_data <= data_in;
    end
  end

endmodule

// File: rtl/vx_ibuffer_reader.sv
// Consumer end of one ibuffer issue slice: pops entries, tags MMUL
// micro-op triples for atomic issue, flags ordering errors, counts perf events.
module vx_ibuffer_reader
  import vx_ibuffer_reader_pkg::*;
#(
  parameter int CORE_ID  = 0,
  parameter int ISSUE_ID = 0,
  parameter int PERF_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [IBUF_DATAW-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [IBUF_DATAW-1:0] out_data,
  output logic                  out_grp_first,
  output logic                  out_grp_last,
  input  logic                  out_ready,
  output logic                  ibuf_pop,
  output logic                  mmul_active,
  output logic                  mmul_seq_err,
  output logic [PERF_W-1:0]     perf_mmul_grps,
  output logic [PERF_W-1:0]     perf_stalls
);

  // Slice identity is trace-only; this empty scope keeps it in the hierarchy
  if (CORE_ID >= 0 && ISSUE_ID >= 0) begin : g_slice_id
  end

  ibuf_entry_t  entry;
  ibuf_tagged_t buf_in;
  ibuf_tagged_t buf_out;
  logic         accept;
  logic         ent_mmul;
  logic         ent_part;
  logic         ent_last;
  logic         same_wis;

  logic [1:0]      state;
  logic [1:0]      nxt_state;
  logic [NW_W-1:0] grp_wis;
  logic            tag_first;
  logic            tag_last;
  logic            seq_err;
  logic            grp_done;
  logic            seed_grp;

  assign entry    = ibuf_entry_t'(in_data);
  assign accept   = in_valid && in_ready;
  assign ibuf_pop = accept;
  assign ent_mmul = is_mmul(entry);
  assign ent_part = ent_mmul && (entry.op_mod == MMUL_MOD_PART);
  assign ent_last = ent_mmul && (entry.op_mod == MMUL_MOD_LAST);
  assign same_wis = (entry.wis == grp_wis);

  // Next-state and tag decode for the entry currently offered
  always_comb begin
    nxt_state = state;
    tag_first = 1'b0;
    tag_last  = 1'b1;
    seq_err   = 1'b0;
    grp_done  = 1'b0;
    seed_grp  = 1'b0;
    case (state)
      ST_GRP1: begin
        if (ent_part && same_wis) begin
          nxt_state = ST_GRP2;
          tag_last  = 1'b0;
        end else begin
          seq_err = 1'b1;
        end
      end
      ST_GRP2: begin
        if (ent_last && same_wis) begin
          nxt_state = ST_IDLE;
          grp_done  = 1'b1;
        end else begin
          seq_err = 1'b1;
        end
      end
      default: begin
        if (ent_last) begin
          seq_err = 1'b1;
        end
      end
    endcase
    // A PART that is not a legal continuation starts a fresh triple
    if (ent_part && (state == ST_IDLE || seq_err)) begin
      nxt_state = ST_GRP1;
      tag_first = 1'b1;
      tag_last  = 1'b0;
      seed_grp  = 1'b1;
    end else if (seq_err) begin
      nxt_state = ST_IDLE;
    end
  end

  // FSM state and group owner, advanced only on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      grp_wis <= '0;
    end else if (accept) begin
      state <= nxt_state;
      if (seed_grp) begin
        grp_wis <= entry.wis;
      end
    end
  end

  // Status pulses and saturating perf counters
  always_ff @(posedge clk) begin
    if (reset) begin
      mmul_active    <= 1'b0;
      mmul_seq_err   <= 1'b0;
      perf_mmul_grps <= '0;
      perf_stalls    <= '0;
    end else begin
      mmul_active  <= accept ? (nxt_state != ST_IDLE) : (state != ST_IDLE);
      mmul_seq_err <= accept && seq_err;
      if (accept && grp_done && perf_mmul_grps != '1) begin
        perf_mmul_grps <= perf_mmul_grps + PERF_W'(1);
      end
      if (out_valid && !out_ready && perf_stalls != '1) begin
        perf_stalls <= perf_stalls + PERF_W'(1);
      end
    end
  end

  assign buf_in.data  = entry;
  assign buf_in.first = tag_first;
  assign buf_in.last  = tag_last;

  vx_ibuffer_reader_ebuf #(
    .DATAW (TAGGED_W)
  ) u_ebuf (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (in_valid),
    .data_in   (buf_in),
    .ready_in  (in_ready),
    .valid_out (out_valid),
    .data_out  (buf_out),
    .ready_out (out_ready)
  );

  assign out_data      = buf_out.data;
  assign out_grp_first = out_valid && buf_out.first;
  assign out_grp_last  = out_valid && buf_out.last;

endmodule

// File: tb/tb_vx_ibuffer_reader.sv
// Directed bench for vx_ibuffer_reader: vector table plus stall/reset sequences.
module tb_vx_ibuffer_reader;
  import vx_ibuffer_reader_pkg::*;

  localparam int PW = 3;

  localparam logic [1:0] K_ALU  = 2'd0;
  localparam logic [1:0] K_PART = 2'd1;
  localparam logic [1:0] K_LAST = 2'd2;
  localparam logic [1:0] K_LSU  = 2'd3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  ibuf_entry_t           in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [IBUF_DATAW-1:0] out_data;
  logic                  out_grp_first;
  logic                  out_grp_last;
  logic                  out_ready;
  logic                  ibuf_pop;
  logic                  mmul_active;
  logic                  mmul_seq_err;
  logic [PW-1:0]         perf_mmul_grps;
  logic [PW-1:0]         perf_stalls;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vx_ibuffer_reader #(
    .CORE_ID  (0),
    .ISSUE_ID (0),
    .PERF_W   (PW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_grp_first  (out_grp_first),
    .out_grp_last   (out_grp_last),
    .out_ready      (out_ready),
    .ibuf_pop       (ibuf_pop),
    .mmul_active    (mmul_active),
    .mmul_seq_err   (mmul_seq_err),
    .perf_mmul_grps (perf_mmul_grps),
    .perf_stalls    (perf_stalls)
  );

  typedef struct {
    logic [1:0] kind;
    logic [1:0] wis;
    logic       xf;
    logic       xl;
    logic       xe;
    logic       xa;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ibuf_entry_t make_entry(input logic [1:0] kind, input logic [1:0] wis);
    ibuf_entry_t e;
    e.uuid      = 16'($urandom);
    e.wis       = wis;
    e.tmask     = 4'($urandom);
    e.ex_type   = (kind == K_LSU) ? EX_LSU : EX_ALU;
    e.op_type   = (kind == K_ALU) ? INST_ALU_ADD : INST_ALU_MMUL;
    e.op_mod    = (kind == K_LAST) ? MMUL_MOD_LAST :
                  (kind == K_ALU)  ? 3'($urandom) : MMUL_MOD_PART;
    e.wb        = 1'($urandom);
    e.use_PC    = 1'($urandom);
    e.use_imm   = 1'($urandom);
    e.PC        = $urandom;
    e.imm       = $urandom;
    e.rd        = 6'($urandom);
    e.rs1       = 6'($urandom);
    e.rs2       = 6'($urandom);
    e.rs3       = 6'($urandom);
    e.is_mstore = 1'($urandom);
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    ibuf_entry_t cur;
    ibuf_entry_t p1;
    ibuf_entry_t p2;
    ibuf_entry_t l3;

    // kind, wis, first, last, err, active-after
    for (int i = 0; i < 8; i++) vecs[i] = '{K_ALU, 2'(i), 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{K_PART, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{K_PART, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{K_LAST, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{K_PART, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{K_ALU,  2'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{K_PART, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{K_PART, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{K_PART, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{K_LAST, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{K_LAST, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{K_PART, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{K_PART, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{K_ALU,  2'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{K_LSU,  2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[22] = '{K_PART, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[23] = '{K_LAST, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst out_valid", 128'(out_valid), 128'(0));
    chk("rst first", 128'(out_grp_first), 128'(0));
    chk("rst last", 128'(out_grp_last), 128'(0));
    chk("rst active", 128'(mmul_active), 128'(0));
    chk("rst err", 128'(mmul_seq_err), 128'(0));
    chk("rst grps", 128'(perf_mmul_grps), 128'(0));
    chk("rst stalls", 128'(perf_stalls), 128'(0));
    chk("rst in_ready", 128'(in_ready), 128'(1));
    reset = 1'b0;

    // Back-to-back stream with out_ready=1: each entry appears one cycle later
    for (int i = 0; i < 24; i++) begin
      cur      = make_entry(vecs[i].kind, vecs[i].wis);
      in_data  = cur;
      in_valid = 1'b1;
      #1;
      chk($sformatf("row%0d pop", i), 128'(ibuf_pop), 128'(1));
      step();
      chk($sformatf("row%0d valid", i), 128'(out_valid), 128'(1));
      chk($sformatf("row%0d data", i), 128'(out_data), 128'(cur));
      chk($sformatf("row%0d first", i), 128'(out_grp_first), 128'(vecs[i].xf));
      chk($sformatf("row%0d last", i), 128'(out_grp_last), 128'(vecs[i].xl));
      chk($sformatf("row%0d err", i), 128'(mmul_seq_err), 128'(vecs[i].xe));
      chk($sformatf("row%0d active", i), 128'(mmul_active), 128'(vecs[i].xa));
    end
    in_valid = 1'b0;
    step();
    chk("stream drained", 128'(out_valid), 128'(0));
    chk("stream grps", 128'(perf_mmul_grps), 128'(2));
    chk("stream stalls", 128'(perf_stalls), 128'(0));

    // Stall for 5 cycles mid-triple
    p1 = make_entry(K_PART, 2'd3);
    p2 = make_entry(K_PART, 2'd3);
    l3 = make_entry(K_LAST, 2'd3);
    in_data  = p1;
    in_valid = 1'b1;
    step();
    chk("stall p1 data", 128'(out_data), 128'(p1));
    out_ready = 1'b0;
    in_data   = p2;
    step();
    chk("stall skid full", 128'(in_ready), 128'(0));
    chk("stall p1 held", 128'(out_data), 128'(p1));
    chk("stall active", 128'(mmul_active), 128'(1));
    in_data = l3;
    #1;
    chk("stall no pop", 128'(ibuf_pop), 128'(0));
    for (int c = 0; c < 4; c++) step();
    chk("stall count", 128'(perf_stalls), 128'(5));
    chk("stall p1 still", 128'(out_data), 128'(p1));
    chk("stall first held", 128'(out_grp_first), 128'(1));
    out_ready = 1'b1;
    step();
    chk("stall p2 data", 128'(out_data), 128'(p2));
    chk("stall p2 first", 128'(out_grp_first), 128'(0));
    chk("stall p2 last", 128'(out_grp_last), 128'(0));
    chk("stall skid empty", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    chk("stall l3 data", 128'(out_data), 128'(l3));
    chk("stall l3 last", 128'(out_grp_last), 128'(1));
    chk("stall grps", 128'(perf_mmul_grps), 128'(3));
    chk("stall idle", 128'(mmul_active), 128'(0));
    step();
    chk("stall drained", 128'(out_valid), 128'(0));
    chk("stall count kept", 128'(perf_stalls), 128'(5));

    // Stall counter saturation: 8 more stall cycles on top of 5
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = make_entry(K_ALU, 2'd0);
    for (int c = 0; c < 9; c++) step();
    chk("sat stalls", 128'(perf_stalls), 128'(7));
    chk("sat in_ready", 128'(in_ready), 128'(0));

    // Drain, then reset while in GRP2
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    in_valid = 1'b1;
    in_data  = make_entry(K_PART, 2'd0);
    step();
    in_data = make_entry(K_PART, 2'd0);
    step();
    chk("pre-rst active", 128'(mmul_active), 128'(1));
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    chk("mid rst valid", 128'(out_valid), 128'(0));
    chk("mid rst first", 128'(out_grp_first), 128'(0));
    chk("mid rst last", 128'(out_grp_last), 128'(0));
    chk("mid rst active", 128'(mmul_active), 128'(0));
    chk("mid rst grps", 128'(perf_mmul_grps), 128'(0));
    chk("mid rst stalls", 128'(perf_stalls), 128'(0));
    reset    = 1'b0;
    in_valid = 1'b1;
    cur      = make_entry(K_LAST, 2'd0);
    in_data  = cur;
    step();
    in_valid = 1'b0;
    chk("post rst err", 128'(mmul_seq_err), 128'(1));
    chk("post rst data", 128'(out_data), 128'(cur));
    chk("post rst last", 128'(out_grp_last), 128'(1));
    chk("post rst first", 128'(out_grp_first), 128'(0));
    chk("post rst grps", 128'(perf_mmul_grps), 128'(0));
    step();
    chk("err one pulse", 128'(mmul_seq_err), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
